// File: rtl/update_resolver_if.sv
// Write-request bus between the requesting units and the update resolver.
// The master drives req/data; the slave returns the registered outputs.
interface update_resolver_if #(
  parameter int WIDTH = 8,
  parameter int PORTS = 4
);
  logic [PORTS-1:0]       req;
  logic [PORTS*WIDTH-1:0] data;
  logic [WIDTH-1:0]       value;
  logic [PORTS-1:0]       grant;
  logic                   conflict;
  logic [15:0]            conflict_count;

  modport master (
    output req,
    output data,
    input  value,
    input  grant,
    input  conflict,
    input  conflict_count
  );

  modport slave (
    input  req,
    input  data,
    output value,
    output grant,
    output conflict,
    output conflict_count
  );
endinterface

// File: rtl/update_resolver.sv
// Single clocked owner of a shared register written by PORTS requesters.
// Define UPDATE_RESOLVER_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module update_resolver #(
  parameter int              WIDTH       = 8,
  parameter int              PORTS       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic            clock,
  input  logic            reset,
  update_resolver_if.slave bus
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [WIDTH-1:0] value_q, value_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic             conflict_q, conflict_d;
  logic [15:0]      count_q, count_d;

  logic             any_req;
  logic             multi_req;
  logic [IW-1:0]    win;

  always_comb begin
    any_req   = 1'b0;
    multi_req = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (bus.req[i]) begin
        if (any_req) multi_req = 1'b1;
        any_req = 1'b1;
      end
    end
  end

`ifdef UPDATE_RESOLVER_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;

  function automatic logic [IW-1:0] rr_idx(
    input logic [IW-1:0] p,
    input int            k
  );
    int j;
    j = int'(p) + k;
    if (j >= PORTS) j = j - PORTS;
    return IW'(j);
  endfunction

  // Scan backwards so the position closest to the pointer wins last.
  always_comb begin
    win = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      if (bus.req[rr_idx(ptr_q, k)]) win = rr_idx(ptr_q, k);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_req) begin
      if (int'(win) == PORTS - 1) ptr_d = '0;
      else                        ptr_d = win + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (bus.req[i]) win = IW'(i);
    end
  end
`endif

  always_comb begin
    value_d    = value_q;
    grant_d    = '0;
    conflict_d = multi_req;
    count_d    = count_q;
    if (any_req) begin
      value_d      = bus.data[win*WIDTH +: WIDTH];
      grant_d[win] = 1'b1;
    end
    // Counter saturates rather than wrapping.
    if (multi_req && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q    <= RESET_VALUE;
      grant_q    <= '0;
      conflict_q <= 1'b0;
      count_q    <= '0;
    end else begin
      value_q    <= value_d;
      grant_q    <= grant_d;
      conflict_q <= conflict_d;
      count_q    <= count_d;
    end
  end

  assign bus.value          = value_q;
  assign bus.grant          = grant_q;
  assign bus.conflict       = conflict_q;
  assign bus.conflict_count = count_q;

endmodule
